// File: rtl/frame_ddr3_port_if.sv
// Signal bundle between frame_ddr3_port, its pixel source/sink and the DDR3 app port.
// master is the frame port's view; slave is the surrounding environment's view.
interface frame_ddr3_port_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 28
);
  logic                    init_calib_complete;
  logic                    start;
  logic                    mode;
  logic                    busy;
  logic                    done;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic [ADDR_WIDTH-1:0]   app_addr;
  logic [2:0]              app_cmd;
  logic                    app_en;
  logic                    app_rdy;
  logic [DATA_WIDTH-1:0]   app_wdf_data;
  logic [DATA_WIDTH/8-1:0] app_wdf_mask;
  logic                    app_wdf_wren;
  logic                    app_wdf_end;
  logic                    app_wdf_rdy;
  logic [DATA_WIDTH-1:0]   app_rd_data;
  logic                    app_rd_data_valid;

  modport master (
    input  init_calib_complete, start, mode, in_data, in_valid, out_ready,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output busy, done, in_ready, out_data, out_valid, out_last,
           app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

  modport slave (
    output init_calib_complete, start, mode, in_data, in_valid, out_ready,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  busy, done, in_ready, out_data, out_valid, out_last,
           app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/frame_ddr3_port.sv
// Moves one full frame between a pixel-word stream and a DDR3 app interface, either
// writing it word by word or reading it back in order through a credit-limited FIFO.
module frame_ddr3_port #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 28,
  parameter int unsigned FRAME_W         = 848,
  parameter int unsigned FRAME_H         = 480,
  parameter int unsigned PIX_PER_WORD    = 4,
  parameter int unsigned ADDR_STEP       = 8,
  parameter int unsigned BASE_ADDR       = 0,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic               ui_clk,
  input logic               ui_clk_sync_rst,
  frame_ddr3_port_if.master bus
);
  localparam int unsigned N_WORDS = FRAME_W * FRAME_H / PIX_PER_WORD;
  localparam int unsigned CNT_W   = $clog2(N_WORDS + 1);
  localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned MASK_W  = DATA_WIDTH / 8;

  localparam logic [CNT_W-1:0]      N_CNT     = CNT_W'(N_WORDS);
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(N_WORDS - 1);
  localparam logic [OUT_W:0]        CREDITS   = (OUT_W + 1)'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_INC  = ADDR_WIDTH'(ADDR_STEP);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_FINISH} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_ptr;
  logic [CNT_W-1:0]        wr_cnt;
  logic [CNT_W-1:0]        rd_iss;
  logic [CNT_W-1:0]        rd_del;
  logic [OUT_W-1:0]        outstanding;
  logic [OUT_W-1:0]        fifo_cnt;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [DATA_WIDTH-1:0]   fifo_mem [0:MAX_OUTSTANDING-1];

  logic [ADDR_WIDTH-1:0]   app_addr;
  logic [2:0]              app_cmd;
  logic                    app_en;
  logic [DATA_WIDTH-1:0]   app_wdf_data;
  logic [MASK_W-1:0]       app_wdf_mask;
  logic                    app_wdf_wren;
  logic                    app_wdf_end;

  logic                    in_ready_c;
  logic                    wr_hs_c;
  logic                    rd_issue_c;
  logic                    rd_acc_c;
  logic                    rd_ret_c;
  logic                    out_valid_c;
  logic                    pop_c;
  logic [OUT_W:0]          in_use_c;

  // Credits count both in-flight reads and words parked in the FIFO, so it can never overflow.
  assign in_use_c    = (OUT_W + 1)'(outstanding) + (OUT_W + 1)'(fifo_cnt);
  assign in_ready_c  = (state == S_WRITE) && !app_en && !app_wdf_wren && (wr_cnt < N_CNT);
  assign wr_hs_c     = in_ready_c && bus.in_valid;
  assign rd_issue_c  = (state == S_READ) && (rd_iss < N_CNT) && !app_en && (in_use_c < CREDITS);
  assign rd_acc_c    = (state == S_READ) && app_en && bus.app_rdy;
  assign rd_ret_c    = (state == S_READ) && bus.app_rd_data_valid;
  assign out_valid_c = (fifo_cnt != '0);
  assign pop_c       = out_valid_c && bus.out_ready;

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state        <= S_IDLE;
      addr_ptr     <= ADDR_BASE;
      wr_cnt       <= '0;
      rd_iss       <= '0;
      rd_del       <= '0;
      outstanding  <= '0;
      fifo_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      app_addr     <= '0;
      app_cmd      <= '0;
      app_en       <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
    end else begin
      // Command and write-data channels retire independently of each other.
      if (app_en && bus.app_rdy)            app_en       <= 1'b0;
      if (app_wdf_wren && bus.app_wdf_rdy)  app_wdf_wren <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start && bus.init_calib_complete)
            state <= bus.mode ? S_READ : S_WRITE;
        end
        S_WRITE: begin
          if (wr_hs_c) begin
            app_cmd      <= 3'b000;
            app_addr     <= addr_ptr;
            app_wdf_data <= bus.in_data;
            app_wdf_mask <= '0;
            app_wdf_end  <= 1'b1;
            app_en       <= 1'b1;
            app_wdf_wren <= 1'b1;
            addr_ptr     <= addr_ptr + ADDR_INC;
            wr_cnt       <= wr_cnt + 1'b1;
          end else if (!app_en && !app_wdf_wren && (wr_cnt == N_CNT)) begin
            state <= S_FINISH;
          end
        end
        S_READ: begin
          if (rd_issue_c) begin
            app_cmd  <= 3'b001;
            app_addr <= addr_ptr;
            app_en   <= 1'b1;
            addr_ptr <= addr_ptr + ADDR_INC;
          end
          if (rd_acc_c) rd_iss <= rd_iss + 1'b1;
          if (rd_acc_c && !rd_ret_c)      outstanding <= outstanding + 1'b1;
          else if (!rd_acc_c && rd_ret_c) outstanding <= outstanding - 1'b1;
          if (rd_ret_c) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
          if (rd_ret_c && !pop_c)      fifo_cnt <= fifo_cnt + 1'b1;
          else if (!rd_ret_c && pop_c) fifo_cnt <= fifo_cnt - 1'b1;
          if (pop_c) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            rd_del <= rd_del + 1'b1;
            if (rd_del == LAST_CNT) state <= S_FINISH;
          end
        end
        S_FINISH: begin
          state       <= S_IDLE;
          addr_ptr    <= ADDR_BASE;
          wr_cnt      <= '0;
          rd_iss      <= '0;
          rd_del      <= '0;
          outstanding <= '0;
          fifo_cnt    <= '0;
          wr_ptr      <= '0;
          rd_ptr      <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by fifo_cnt.
  always_ff @(posedge ui_clk) begin
    if (!ui_clk_sync_rst && rd_ret_c) fifo_mem[wr_ptr] <= bus.app_rd_data;
  end

  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = (state == S_FINISH);
  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_c;
  assign bus.out_data     = fifo_mem[rd_ptr];
  assign bus.out_last     = out_valid_c && (rd_del == LAST_CNT);
  assign bus.app_addr     = app_addr;
  assign bus.app_cmd      = app_cmd;
  assign bus.app_en       = app_en;
  assign bus.app_wdf_data = app_wdf_data;
  assign bus.app_wdf_mask = app_wdf_mask;
  assign bus.app_wdf_wren = app_wdf_wren;
  assign bus.app_wdf_end  = app_wdf_end;
endmodule

// File: tb/tb_frame_ddr3_port.sv
// Directed bench for frame_ddr3_port on a 4-word frame at base 0x100 with a small DDR3 app model.
module tb_frame_ddr3_port;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  frame_ddr3_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(28)) bus ();

  frame_ddr3_port #(
    .DATA_WIDTH(32), .ADDR_WIDTH(28), .FRAME_W(8), .FRAME_H(2), .PIX_PER_WORD(4),
    .ADDR_STEP(8), .BASE_ADDR(32'h100), .MAX_OUTSTANDING(4)
  ) dut (
    .ui_clk(clk),
    .ui_clk_sync_rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DDR3 model: decides on the falling edge what the DUT will see at the next rising edge.
  logic [31:0] mem [0:15];
  logic [27:0] rd_pend_q [$];
  logic [27:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          rd_cmd_cnt;
  int          mem_wr_done;

  function automatic logic [3:0] idx(input logic [27:0] a);
    return 4'((a - 28'h100) >> 3);
  endfunction

  always @(negedge clk) begin
    if (rd_pend_q.size() > 0) begin
      bus.app_rd_data       = mem[idx(rd_pend_q[0])];
      bus.app_rd_data_valid = 1'b1;
      void'(rd_pend_q.pop_front());
    end else begin
      bus.app_rd_data       = 32'h0;
      bus.app_rd_data_valid = 1'b0;
    end
    if (bus.app_en && bus.app_rdy) begin
      if (bus.app_cmd == 3'b001) begin
        rd_pend_q.push_back(bus.app_addr);
        rd_cmd_cnt++;
      end else if (bus.app_cmd == 3'b000) begin
        wr_addr_q.push_back(bus.app_addr);
      end
    end
    if (bus.app_wdf_wren && bus.app_wdf_rdy) wr_data_q.push_back(bus.app_wdf_data);
    while (mem_wr_done < wr_addr_q.size() && mem_wr_done < wr_data_q.size()) begin
      mem[idx(wr_addr_q[mem_wr_done])] = wr_data_q[mem_wr_done];
      mem_wr_done++;
    end
  end

  task automatic clear_model();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_pend_q.delete();
    mem_wr_done = 0;
    rd_cmd_cnt  = 0;
  endtask

  task automatic do_start(input logic m);
    bus.start = 1'b1;
    bus.mode  = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_words(input logic [31:0] base, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int cyc = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = base + 32'(i);
      while (!bus.in_ready && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      n_tests++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL send_word%0d: in_ready got %b required 1 (timeout)", i, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    int pulses = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: done got %b required 1 (timeout)", name, bus.done);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL %s_done_width: extra done cycles got %0d required 0", name, pulses);
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_drop: busy got %b required 0", name, bus.busy);
    end
  endtask

  task automatic check_writes(input string name, input logic [31:0] base);
    n_tests++;
    if (wr_addr_q.size() != 4 || wr_data_q.size() != 4) begin
      n_fail++;
      $display("FAIL %s_count: writes got addr=%0d data=%0d required 4/4", name,
               wr_addr_q.size(), wr_data_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [27:0] ea;
      logic [31:0] ed;
      ea = 28'h100 + 28'(8 * i);
      ed = base + 32'(i);
      n_tests++;
      if (i >= wr_addr_q.size() || i >= wr_data_q.size()) begin
        n_fail++;
        $display("FAIL %s_word%0d: missing, required addr %0h data %0h", name, i, ea, ed);
      end else if (wr_addr_q[i] !== ea || wr_data_q[i] !== ed) begin
        n_fail++;
        $display("FAIL %s_word%0d: got addr %0h data %0h required addr %0h data %0h", name, i,
                 wr_addr_q[i], wr_data_q[i], ea, ed);
      end
    end
  endtask

  task automatic collect(input string name, input logic [31:0] base);
    int got = 0;
    int cyc = 0;
    while (got < 4 && cyc < 300) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_tests++;
        if (bus.out_data !== base + 32'(got) || bus.out_last !== 1'(got == 3)) begin
          n_fail++;
          $display("FAIL %s_word%0d: got data %0h last %b required data %0h last %b", name, got,
                   bus.out_data, bus.out_last, base + 32'(got), 1'(got == 3));
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL %s_delivered: words got %0d required 4", name, got);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.out_last, bus.app_en,
         bus.app_wdf_wren, bus.app_wdf_end} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000000", {bus.busy, bus.done, bus.in_ready,
               bus.out_valid, bus.out_last, bus.app_en, bus.app_wdf_wren, bus.app_wdf_end});
    end
    n_tests++;
    if ({bus.app_cmd, bus.app_addr, bus.app_wdf_data, bus.app_wdf_mask} !== 67'b0) begin
      n_fail++;
      $display("FAIL reset_bus: got cmd %0h addr %0h wdata %0h mask %0h required all 0",
               bus.app_cmd, bus.app_addr, bus.app_wdf_data, bus.app_wdf_mask);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    clear_model();
    do_start(1'b0);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_busy: busy got %b required 1", bus.busy);
    end
    send_words(32'hA0, 0, 3);
    wait_done("write");
    check_writes("write", 32'hA0);
  endtask

  task automatic test_read();
    clear_model();
    bus.out_ready = 1'b1;
    do_start(1'b1);
    collect("read", 32'hA0);
    wait_done("read");
  endtask

  task automatic test_wdf_stall();
    int cyc = 0;
    clear_model();
    bus.app_wdf_rdy = 1'b0;
    do_start(1'b0);
    while (!bus.in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hB0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_tests++;
    if ({bus.app_en, bus.app_wdf_wren} !== 2'b11) begin
      n_fail++;
      $display("FAIL stall_issue: en/wren got %b required 11", {bus.app_en, bus.app_wdf_wren});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({bus.app_en, bus.app_wdf_wren, bus.in_ready} !== 3'b010) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: en/wren/in_ready got %b required 010", i,
                 {bus.app_en, bus.app_wdf_wren, bus.in_ready});
      end
    end
    bus.app_wdf_rdy = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.app_wdf_wren, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_release: wren/in_ready got %b required 01",
               {bus.app_wdf_wren, bus.in_ready});
    end
    send_words(32'hB0, 1, 3);
    wait_done("stall");
    check_writes("stall", 32'hB0);
  endtask

  task automatic test_read_backpressure();
    clear_model();
    bus.out_ready = 1'b0;
    do_start(1'b1);
    repeat (20) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (rd_cmd_cnt != 4) begin
      n_fail++;
      $display("FAIL bp_cmds: read commands got %0d required 4", rd_cmd_cnt);
    end
    n_tests++;
    if ({bus.app_en, bus.out_valid, bus.done} !== 3'b010) begin
      n_fail++;
      $display("FAIL bp_hold: en/out_valid/done got %b required 010",
               {bus.app_en, bus.out_valid, bus.done});
    end
    n_tests++;
    if (bus.out_data !== 32'hB0) begin
      n_fail++;
      $display("FAIL bp_head: out_data got %0h required b0", bus.out_data);
    end
    bus.out_ready = 1'b1;
    collect("bp", 32'hB0);
    wait_done("bp");
    n_tests++;
    if (rd_cmd_cnt != 4) begin
      n_fail++;
      $display("FAIL bp_total_cmds: read commands got %0d required 4", rd_cmd_cnt);
    end
  endtask

  task automatic test_reset_midwrite();
    clear_model();
    do_start(1'b0);
    send_words(32'hC0, 0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.out_last, bus.app_en,
         bus.app_wdf_wren, bus.app_wdf_end} !== 8'b0) begin
      n_fail++;
      $display("FAIL midreset_flags: got %b required 00000000", {bus.busy, bus.done,
               bus.in_ready, bus.out_valid, bus.out_last, bus.app_en, bus.app_wdf_wren,
               bus.app_wdf_end});
    end
    n_tests++;
    if ({bus.app_cmd, bus.app_addr, bus.app_wdf_data, bus.app_wdf_mask} !== 67'b0) begin
      n_fail++;
      $display("FAIL midreset_bus: got cmd %0h addr %0h wdata %0h mask %0h required all 0",
               bus.app_cmd, bus.app_addr, bus.app_wdf_data, bus.app_wdf_mask);
    end
    rst = 1'b0;
    bus.init_calib_complete = 1'b0;
    do_start(1'b0);
    @(posedge clk); #1;
    n_tests++;
    if ({bus.busy, bus.in_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL nocalib_ignored: busy/in_ready got %b required 00", {bus.busy, bus.in_ready});
    end
    bus.init_calib_complete = 1'b1;
    clear_model();
    do_start(1'b0);
    send_words(32'hC0, 0, 3);
    wait_done("rewrite");
    check_writes("rewrite", 32'hC0);
    clear_model();
    bus.out_ready = 1'b1;
    do_start(1'b1);
    collect("reread", 32'hC0);
    wait_done("reread");
  endtask

  initial begin
    n_tests                 = 0;
    n_fail                  = 0;
    rd_cmd_cnt              = 0;
    mem_wr_done             = 0;
    rst                     = 1'b1;
    bus.init_calib_complete = 1'b1;
    bus.start               = 1'b0;
    bus.mode                = 1'b0;
    bus.in_data             = 32'h0;
    bus.in_valid            = 1'b0;
    bus.out_ready           = 1'b1;
    bus.app_rdy             = 1'b1;
    bus.app_wdf_rdy         = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_wdf_stall();
    test_read_backpressure();
    test_reset_midwrite();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
